// File: rtl/evr_marker_pkg.sv
// Shared constants and types for the EVR marker decoder.
package evr_marker_pkg;

  // Reset-default event codes for the heartbeat and pulse-per-second markers.
  localparam logic [7:0] HB_CODE  = 8'h7A;
  localparam logic [7:0] PPS_CODE = 8'h7D;

  // Width of the marker stretch counter; limits marker high time to 255 cycles.
  localparam int unsigned MARKER_CNT_WIDTH = 8;

  // Marker stretcher states.
  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACTIVE
  } stretch_state_e;

endpackage

// File: rtl/evr_marker_stretch.sv
// Stretches a single-cycle hit into a marker that is high for exactly 'width' cycles.
// A hit while the marker is already high is dropped (no restart) and reported on
// overrunPulse, so every marker returns low before the next rising edge.
module evr_marker_stretch
  import evr_marker_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        hit,
  input  logic [MARKER_CNT_WIDTH-1:0] width,
  output logic                        marker,
  output logic                        overrunPulse
);

  localparam logic [MARKER_CNT_WIDTH-1:0] CntOne = {{(MARKER_CNT_WIDTH-1){1'b0}}, 1'b1};

  stretch_state_e              state_q, state_d;
  logic [MARKER_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // State and remaining-cycle counter; reset drops the marker immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arm on a hit from idle, count down while active, flag ignored hits.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    overrunPulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACTIVE;
          cnt_d   = width - CntOne;
        end
      end
      ST_ACTIVE: begin
        overrunPulse = hit;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Marker is a pure function of state so it is glitch-free and resets asynchronously.
  assign marker = (state_q == ST_ACTIVE);

endmodule

// File: rtl/evr_marker_decoder.sv
// EVR event-code decoder: produces stretched heartbeat / PPS markers, measures the
// heartbeat period in evrClk cycles and keeps sticky overrun flags.
// Optional build macro EVR_MARKER_TIMESTAMP_EN adds evrSeconds / evrTicks outputs.
module evr_marker_decoder #(
  parameter logic [7:0]  HB_CODE      = evr_marker_pkg::HB_CODE,
  parameter logic [7:0]  PPS_CODE     = evr_marker_pkg::PPS_CODE,
  parameter int unsigned MARKER_WIDTH = 8,
  parameter int unsigned PERIOD_WIDTH = 32
) (
  input  logic                    evrClk,
  input  logic                    evrRstN,
  input  logic [7:0]              evrEventCode,
  input  logic                    evrEventValid,
  input  logic                    evrCfgStrobe,
  input  logic [7:0]              evrCfgHbCode,
  input  logic [7:0]              evrCfgPpsCode,
  input  logic                    evrClearStatus,
  output logic                    evrHeartbeatMarker,
  output logic                    evrPulsePerSecondMarker,
  output logic [PERIOD_WIDTH-1:0] evrHbPeriod,
  output logic                    evrHbPeriodValid,
  output logic                    evrHbPeriodStable,
`ifdef EVR_MARKER_TIMESTAMP_EN
  output logic [31:0]             evrSeconds,
  output logic [31:0]             evrTicks,
`endif
  output logic                    evrHbOverrun,
  output logic                    evrPpsOverrun
);

  import evr_marker_pkg::*;

  localparam logic [MARKER_CNT_WIDTH-1:0] MarkerWidthW = MARKER_WIDTH[MARKER_CNT_WIDTH-1:0];
  localparam logic [PERIOD_WIDTH-1:0]     PeriodOne    = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Programmable event codes
  // ---------------------------------------------------------------------------
  logic [7:0] hb_code_q, hb_code_d;
  logic [7:0] pps_code_q, pps_code_d;
  logic       hb_hit, pps_hit;
  logic       hb_code_change;

  // Matching uses the registered codes, so a hit coinciding with a strobe sees the old codes.
  assign hb_hit         = evrEventValid && (evrEventCode == hb_code_q);
  assign pps_hit        = evrEventValid && (evrEventCode == pps_code_q);
  assign hb_code_change = evrCfgStrobe && (evrCfgHbCode != hb_code_q);

  // Code register next-state: both codes load together on a strobe.
  always_comb begin
    hb_code_d  = hb_code_q;
    pps_code_d = pps_code_q;
    if (evrCfgStrobe) begin
      hb_code_d  = evrCfgHbCode;
      pps_code_d = evrCfgPpsCode;
    end
  end

  // Code registers.
  always_ff @(posedge evrClk or negedge evrRstN) begin
    if (!evrRstN) begin
      hb_code_q  <= HB_CODE;
      pps_code_q <= PPS_CODE;
    end else begin
      hb_code_q  <= hb_code_d;
      pps_code_q <= pps_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Marker stretchers
  // ---------------------------------------------------------------------------
  logic hb_ovr_pulse, pps_ovr_pulse;

  evr_marker_stretch u_hb_stretch (
    .clk          (evrClk),
    .resetN       (evrRstN),
    .hit          (hb_hit),
    .width        (MarkerWidthW),
    .marker       (evrHeartbeatMarker),
    .overrunPulse (hb_ovr_pulse)
  );

  evr_marker_stretch u_pps_stretch (
    .clk          (evrClk),
    .resetN       (evrRstN),
    .hit          (pps_hit),
    .width        (MarkerWidthW),
    .marker       (evrPulsePerSecondMarker),
    .overrunPulse (pps_ovr_pulse)
  );

  // ---------------------------------------------------------------------------
  // Sticky overrun flags and heartbeat period measurement
  // ---------------------------------------------------------------------------
  logic                    hb_ovr_q, hb_ovr_d;
  logic                    pps_ovr_q, pps_ovr_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                    capture_en_q, capture_en_d;
  logic [PERIOD_WIDTH-1:0] hb_period_q, hb_period_d;
  logic                    period_valid_q, period_valid_d;
  logic                    period_stable_q, period_stable_d;
  logic                    period_sat;
  logic [PERIOD_WIDTH-1:0] period_next;

  assign period_sat  = &period_cnt_q;
  // Period counts the hit cycle itself, so heartbeats every N cycles report N.
  assign period_next = period_cnt_q + PeriodOne;

  // Overrun flags: a new overrun beats a simultaneous clear.
  always_comb begin
    hb_ovr_d  = hb_ovr_q;
    pps_ovr_d = pps_ovr_q;
    if (evrClearStatus) begin
      hb_ovr_d  = 1'b0;
      pps_ovr_d = 1'b0;
    end
    if (hb_ovr_pulse) begin
      hb_ovr_d = 1'b1;
    end
    if (pps_ovr_pulse) begin
      pps_ovr_d = 1'b1;
    end
  end

  // Period next-state: every heartbeat hit (even one the stretcher ignored) closes a period.
  always_comb begin
    period_cnt_d    = period_sat ? period_cnt_q : period_next;
    capture_en_d    = capture_en_q;
    hb_period_d     = hb_period_q;
    period_valid_d  = period_valid_q;
    period_stable_d = period_stable_q;
    if (evrClearStatus) begin
      period_stable_d = 1'b0;
    end
    if (hb_hit) begin
      period_cnt_d = '0;
      capture_en_d = 1'b1;
      if (capture_en_q) begin
        if (!period_sat) begin
          hb_period_d     = period_next;
          period_valid_d  = 1'b1;
          period_stable_d = (period_next == hb_period_q) && period_valid_q;
        end else begin
          // Period too long to represent: report no measurement rather than a wrong one.
          period_valid_d  = 1'b0;
          period_stable_d = 1'b0;
        end
      end
    end
    // A new heartbeat code invalidates any measurement taken against the old one.
    if (hb_code_change) begin
      capture_en_d    = 1'b0;
      period_valid_d  = 1'b0;
      period_stable_d = 1'b0;
    end
  end

  // Status and period registers.
  always_ff @(posedge evrClk or negedge evrRstN) begin
    if (!evrRstN) begin
      hb_ovr_q        <= 1'b0;
      pps_ovr_q       <= 1'b0;
      period_cnt_q    <= '0;
      capture_en_q    <= 1'b0;
      hb_period_q     <= '0;
      period_valid_q  <= 1'b0;
      period_stable_q <= 1'b0;
    end else begin
      hb_ovr_q        <= hb_ovr_d;
      pps_ovr_q       <= pps_ovr_d;
      period_cnt_q    <= period_cnt_d;
      capture_en_q    <= capture_en_d;
      hb_period_q     <= hb_period_d;
      period_valid_q  <= period_valid_d;
      period_stable_q <= period_stable_d;
    end
  end

  assign evrHbOverrun      = hb_ovr_q;
  assign evrPpsOverrun     = pps_ovr_q;
  assign evrHbPeriod       = hb_period_q;
  assign evrHbPeriodValid  = period_valid_q;
  assign evrHbPeriodStable = period_stable_q;

`ifdef EVR_MARKER_TIMESTAMP_EN
  // ---------------------------------------------------------------------------
  // Seconds / ticks timestamp driven by the PPS code
  // ---------------------------------------------------------------------------
  logic [31:0] seconds_q, seconds_d;
  logic [31:0] ticks_q, ticks_d;

  // Ticks saturate rather than wrap; seconds wrap naturally at 2^32.
  always_comb begin
    seconds_d = seconds_q;
    ticks_d   = (&ticks_q) ? ticks_q : ticks_q + 32'd1;
    if (pps_hit) begin
      seconds_d = seconds_q + 32'd1;
      ticks_d   = '0;
    end
  end

  // Timestamp registers.
  always_ff @(posedge evrClk or negedge evrRstN) begin
    if (!evrRstN) begin
      seconds_q <= '0;
      ticks_q   <= '0;
    end else begin
      seconds_q <= seconds_d;
      ticks_q   <= ticks_d;
    end
  end

  assign evrSeconds = seconds_q;
  assign evrTicks   = ticks_q;
`endif

endmodule

// File: tb/tb_evr_marker_decoder.sv
// Self-checking bench for evr_marker_decoder: vector table, directed corner cases and
// a randomized run against a time-based reference model.
module tb_evr_marker_decoder;

  localparam int unsigned W     = 8;
  localparam longint      MAX32 = 64'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code;
  logic       valid, strobe, clear;
  logic [7:0] cfg_hb, cfg_pps;

  logic        hb0, pps0, val0, stb0, hbo0, ppso0;
  logic [31:0] per0;
  logic        hb1, pps1, val1, stb1, hbo1, ppso1;
  logic [7:0]  per1;
`ifdef EVR_MARKER_TIMESTAMP_EN
  logic [31:0] secs0, ticks0, secs1, ticks1;
`endif

  always #5 clk = ~clk;

  evr_marker_decoder u_dut (
    .evrClk                  (clk),
    .evrRstN                 (rst_n),
    .evrEventCode            (code),
    .evrEventValid           (valid),
    .evrCfgStrobe            (strobe),
    .evrCfgHbCode            (cfg_hb),
    .evrCfgPpsCode           (cfg_pps),
    .evrClearStatus          (clear),
    .evrHeartbeatMarker      (hb0),
    .evrPulsePerSecondMarker (pps0),
    .evrHbPeriod             (per0),
    .evrHbPeriodValid        (val0),
    .evrHbPeriodStable       (stb0),
`ifdef EVR_MARKER_TIMESTAMP_EN
    .evrSeconds              (secs0),
    .evrTicks                (ticks0),
`endif
    .evrHbOverrun            (hbo0),
    .evrPpsOverrun           (ppso0)
  );

  evr_marker_decoder #(.PERIOD_WIDTH(8)) u_dut8 (
    .evrClk                  (clk),
    .evrRstN                 (rst_n),
    .evrEventCode            (code),
    .evrEventValid           (valid),
    .evrCfgStrobe            (strobe),
    .evrCfgHbCode            (cfg_hb),
    .evrCfgPpsCode           (cfg_pps),
    .evrClearStatus          (clear),
    .evrHeartbeatMarker      (hb1),
    .evrPulsePerSecondMarker (pps1),
    .evrHbPeriod             (per1),
    .evrHbPeriodValid        (val1),
    .evrHbPeriodStable       (stb1),
`ifdef EVR_MARKER_TIMESTAMP_EN
    .evrSeconds              (secs1),
    .evrTicks                (ticks1),
`endif
    .evrHbOverrun            (hbo1),
    .evrPpsOverrun           (ppso1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: markers and periods derived from cycle numbers of hits.
  // m_cyc is the number of rising edges since reset release.
  // ---------------------------------------------------------------------------
  longint     m_cyc, m_hb_start, m_pps_start, m_last_hb, m_last_pps, m_gap;
  logic [7:0] m_hb_code, m_pps_code;
  logic       m_hb_ovr, m_pps_ovr, m_cap, m_valid, m_stable;
  logic [31:0] m_period, m_secs;
  logic       mh, mp, m_hset, m_pset, m_s;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_hb_code = 8'h7A; m_pps_code = 8'h7D;
      m_hb_start = -1000; m_pps_start = -1000; m_last_hb = 0; m_last_pps = 0;
      m_hb_ovr = 0; m_pps_ovr = 0; m_cap = 0; m_valid = 0; m_stable = 0;
      m_period = 0; m_secs = 0;
    end else begin
      mh = valid && (code == m_hb_code);
      mp = valid && (code == m_pps_code);
      // A hit is an overrun if the marker was high during the cycle it arrived in.
      m_hset = 0; m_pset = 0;
      if (mh) begin
        if (m_cyc - m_hb_start < W) m_hset = 1; else m_hb_start = m_cyc + 1;
      end
      if (mp) begin
        if (m_cyc - m_pps_start < W) m_pset = 1; else m_pps_start = m_cyc + 1;
      end
      m_hb_ovr  = m_hset || (m_hb_ovr && !clear);
      m_pps_ovr = m_pset || (m_pps_ovr && !clear);
      m_s = m_stable && !clear;
      if (mh) begin
        m_gap = m_cyc + 1 - m_last_hb;
        if (m_cap) begin
          if (m_gap <= MAX32) begin
            m_s = (m_gap == longint'(m_period)) && m_valid;
            m_period = m_gap[31:0];
            m_valid = 1;
          end else begin
            m_valid = 0; m_s = 0;
          end
        end
        m_last_hb = m_cyc + 1;
        m_cap = 1;
      end
      if (strobe && cfg_hb != m_hb_code) begin
        m_cap = 0; m_valid = 0; m_s = 0;
      end
      m_stable = m_s;
      if (strobe) begin
        m_hb_code = cfg_hb; m_pps_code = cfg_pps;
      end
      if (mp) begin
        m_secs = m_secs + 1; m_last_pps = m_cyc + 1;
      end
      m_cyc++;
    end
  end

  task automatic check_model();
    check("rnd_hb", hb0, (m_cyc - m_hb_start) < W);
    check("rnd_pps", pps0, (m_cyc - m_pps_start) < W);
    check("rnd_hbo", hbo0, m_hb_ovr);
    check("rnd_ppso", ppso0, m_pps_ovr);
    check("rnd_period", per0, m_period);
    check("rnd_valid", val0, m_valid);
    check("rnd_stable", stb0, m_stable);
`ifdef EVR_MARKER_TIMESTAMP_EN
    check("rnd_secs", secs0, m_secs);
    check("rnd_ticks", ticks0, (m_cyc - m_last_pps) > MAX32 ? MAX32 : m_cyc - m_last_pps);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge, outputs sampled there too.
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    valid = 0; code = 8'h00; strobe = 0; clear = 0; cfg_hb = 8'h7A; cfg_pps = 8'h7D;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic hit(input logic [7:0] c);
    valid = 1; code = c;
    step();
    valid = 0; code = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hb"}, hb0, 0);
    check({tag, "_pps"}, pps0, 0);
    check({tag, "_period"}, per0, 0);
    check({tag, "_valid"}, val0, 0);
    check({tag, "_stable"}, stb0, 0);
    check({tag, "_hbo"}, hbo0, 0);
    check({tag, "_ppso"}, ppso0, 0);
`ifdef EVR_MARKER_TIMESTAMP_EN
    check({tag, "_secs"}, secs0, 0);
    check({tag, "_ticks"}, ticks0, 0);
`endif
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] code;
    logic       clear;
    logic       e_hb, e_pps, e_hbo, e_ppso, e_val, e_stb;
    logic [31:0] e_per;
  } vec_t;

  vec_t vec[40];

  initial begin
    // Vector table: heartbeat at 5 (overrun at 9), PPS at 14 (overrun at 18),
    // heartbeats 24/26/28 with a clear at 28 (set wins) and a plain clear at 30.
    for (int i = 0; i < 40; i++) begin
      vec[i].valid = 0; vec[i].code = 8'h00; vec[i].clear = 0;
      vec[i].e_hb   = (i >= 5 && i <= 12) || (i >= 24 && i <= 31);
      vec[i].e_pps  = (i >= 14 && i <= 21);
      vec[i].e_hbo  = (i >= 9 && i <= 15) || (i >= 26 && i <= 29);
      vec[i].e_ppso = (i >= 18 && i <= 27);
      vec[i].e_per  = (i < 9) ? 0 : (i < 24) ? 4 : (i < 26) ? 15 : 2;
      vec[i].e_val  = (i >= 9);
      vec[i].e_stb  = (i >= 28 && i <= 29);
    end
    foreach (vec[i]) begin
      if (i == 5 || i == 9 || i == 24 || i == 26 || i == 28) begin
        vec[i].valid = 1; vec[i].code = 8'h7A;
      end
      if (i == 14 || i == 18) begin
        vec[i].valid = 1; vec[i].code = 8'h7D;
      end
      if (i == 16 || i == 28 || i == 30) vec[i].clear = 1;
    end

    rst_n = 0;
    idle_inputs();
    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 40; i++) begin
      valid = vec[i].valid; code = vec[i].code; clear = vec[i].clear;
      step();
      check($sformatf("vec%0d_hb", i), hb0, vec[i].e_hb);
      check($sformatf("vec%0d_pps", i), pps0, vec[i].e_pps);
      check($sformatf("vec%0d_hbo", i), hbo0, vec[i].e_hbo);
      check($sformatf("vec%0d_ppso", i), ppso0, vec[i].e_ppso);
      check($sformatf("vec%0d_period", i), per0, vec[i].e_per);
      check($sformatf("vec%0d_valid", i), val0, vec[i].e_val);
      check($sformatf("vec%0d_stable", i), stb0, vec[i].e_stb);
    end
    idle_inputs();

    // Heartbeats 1000 cycles apart.
    do_reset();
    hit(8'h7A); idle(999); hit(8'h7A);
    check("p1000_period", per0, 1000);
    check("p1000_valid", val0, 1);
    check("p1000_stable0", stb0, 0);
    idle(999); hit(8'h7A);
    check("p1000_stable1", stb0, 1);

    // Code change on the same cycle as an old-code heartbeat.
    do_reset();
    hit(8'h7A); idle(49); hit(8'h7A);
    check("cfg_pre_valid", val0, 1);
    idle(10);
    valid = 1; code = 8'h7A; strobe = 1; cfg_hb = 8'h20; cfg_pps = 8'h7D;
    step();
    idle_inputs();
    check("cfg_old_fires", hb0, 1);
    check("cfg_valid_clr", val0, 0);
    idle(10);
    hit(8'h7A);
    check("cfg_old_ignored", hb0, 0);
    idle(10);
    hit(8'h20);
    check("cfg_new_fires", hb0, 1);
    idle(29); hit(8'h20);
    check("cfg_new_period", per0, 30);
    check("cfg_new_valid", val0, 1);

    // 8-bit period counter saturation.
    do_reset();
    hit(8'h7A); idle(299); hit(8'h7A);
    check("sat_valid", val1, 0);
    idle(99); hit(8'h7A);
    check("sat_period", per1, 100);
    check("sat_valid2", val1, 1);

`ifdef EVR_MARKER_TIMESTAMP_EN
    // PPS timestamp.
    do_reset();
    hit(8'h7D);
    check("ts_secs1", secs0, 1);
    check("ts_ticks1", ticks0, 0);
    idle(499);
    check("ts_ticks499", ticks0, 499);
    hit(8'h7D);
    check("ts_secs2", secs0, 2);
    check("ts_ticks2", ticks0, 0);
`endif

    // Asynchronous reset in the middle of a marker.
    do_reset();
    hit(8'h7A); hit(8'h7D); idle(2);
    check("mid_hb_up", hb0, 1);
    #2 rst_n = 0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1;

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      check_model();
      valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: code = 8'h7A;
        1: code = 8'h7D;
        2: code = 8'h20;
        3: code = 8'h55;
        default: code = 8'($urandom);
      endcase
      clear  = ($urandom_range(0, 29) == 0);
      strobe = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 3))
        0: cfg_hb = 8'h7A;
        1: cfg_hb = 8'h7D;
        2: cfg_hb = 8'h20;
        default: cfg_hb = 8'h55;
      endcase
      case ($urandom_range(0, 3))
        0: cfg_pps = 8'h7A;
        1: cfg_pps = 8'h7D;
        2: cfg_pps = 8'h20;
        default: cfg_pps = 8'h55;
      endcase
      step();
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
